pwm_halfbridge_capture: RTL
===========================

PWM_HALFBRIDGE_CAPTURE -- requirements
Module: pwm_halfbridge_capture

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8192: clocks without a qualifying edge before a static decode is made.
REQ-002 The block SHALL have parameter MIDSCALE, default 2048: the duty code for both channels static with high-side on.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port PWM_IN_HI, input, 1 bit: high-side gate drive, active-low, asynchronous to clock.
REQ-006 The block SHALL have port PWM_IN_LO, input, 1 bit: low-side gate drive, active-high, asynchronous to clock.
REQ-007 The block SHALL have port DUTY_OUT, output, 32 bits: the reconstructed duty code, range 0..4095.
REQ-008 The block SHALL have port DUTY_VALID, output, 1 bit: a one-clock strobe when DUTY_OUT updates.
REQ-009 The block SHALL have port PERIOD_OUT, output, 16 bits: last rising-to-rising period in clocks, saturating at 65535.
REQ-010 The block SHALL have port NO_SIGNAL, output, 1 bit: high-side off and low side idle past TIMEOUT.
REQ-011 The block SHALL have port FAULT, output, 1 bit: sticky shoot-through flag.

Function
REQ-012 The block SHALL pass each input through a 2-flop synchronizer, giving h = ~sync(PWM_IN_HI) and l = sync(PWM_IN_LO), followed by a 1-flop edge detector.
REQ-013 The block SHALL implement states IDLE, HIGH and LOW, plus a 2-bit source register with values NONE, H and L.
REQ-014 In IDLE or LOW, a rising edge on h while l=0 SHALL select source H and enter HIGH.
REQ-015 In IDLE or LOW, a rising edge on l while h=1 SHALL select source L and enter HIGH.
REQ-016 On entering HIGH, the 12-bit width counter SHALL load 1 and increment each clock the source is high, saturating at 4095.
REQ-017 When a falling edge on the source is detected in HIGH, the block SHALL enter LOW.
REQ-018 On that falling edge with source H, the next clock SHALL set DUTY_OUT = width-1 and pulse DUTY_VALID.
REQ-019 On that falling edge with source L, the next clock SHALL set DUTY_OUT = MIDSCALE + width-1, saturating at 4095, and pulse DUTY_VALID.
REQ-020 A 16-bit period counter SHALL restart at each rising edge on the source; PERIOD_OUT SHALL load the count at the next source rising edge, saturating at 65535.
REQ-021 A rising edge on the non-selected channel in HIGH or LOW SHALL reselect the source and restart HIGH; no DUTY_VALID is produced for the aborted pulse.
REQ-022 A 16-bit idle counter SHALL clear on any h or l edge and increment otherwise.
REQ-023 At idle count = TIMEOUT, with h=1 and l=0, the block SHALL set DUTY_OUT = MIDSCALE, pulse DUTY_VALID, clear the idle counter, and enter IDLE with source NONE.
REQ-024 At idle count = TIMEOUT, with h=0 and l=0, the block SHALL set NO_SIGNAL=1, DUTY_OUT=0, pulse DUTY_VALID, clear the idle counter, and enter IDLE.
REQ-025 At idle count = TIMEOUT, with h=1 and l=1, the block SHALL treat the channel as a saturated L source: DUTY_OUT=4095, pulse DUTY_VALID.
REQ-026 While static, the timeout decode of REQ-023..REQ-025 SHALL repeat every TIMEOUT clocks.
REQ-027 NO_SIGNAL SHALL clear on the next h or l rising edge.
REQ-028 FAULT SHALL set when l=1 and h=0 for 2 or more consecutive clocks; it holds until reset, and measurement continues.
REQ-029 If a falling edge and a timeout occur in the same clock, the falling-edge result SHALL win and the idle counter SHALL clear.
REQ-030 At most one DUTY_VALID SHALL be produced per clock.
REQ-031 DUTY_OUT bits [31:12] SHALL always be 0.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE, source NONE, and clear all counters, synchronizers and edge registers.
REQ-033 During reset, DUTY_OUT, PERIOD_OUT, DUTY_VALID, NO_SIGNAL and FAULT SHALL all be 0.
REQ-034 Reset asserted mid-pulse SHALL discard the pulse; after release, no DUTY_VALID SHALL occur before a complete new pulse or a full TIMEOUT.

Verification
REQ-035 Lower half: LO=0; HI low for 101 clocks every 2049 -> DUTY_OUT=100, DUTY_VALID once per frame, PERIOD_OUT=2049 from the 2nd frame.
REQ-036 Upper half: HI held 0; LO high for 301 clocks every 2049 -> DUTY_OUT=2348, one strobe per frame.
REQ-037 Midscale: HI=0 and LO=0 static after edges -> after 8192 clocks DUTY_OUT=2048, strobe repeats every 8192 clocks, NO_SIGNAL=0.
REQ-038 No signal: HI=1 and LO=0 static from reset release -> NO_SIGNAL=1, DUTY_OUT=0 at clock 8192 plus synchronizer delay.
REQ-039 Fault: HI=1 and LO=1 for 3 clocks mid-frame -> FAULT=1, held through later valid frames until reset.
REQ-040 Boundaries: a 1-clock HI pulse gives DUTY_OUT=0; a 5000-clock LO pulse gives DUTY_OUT=4095; reset mid-pulse gives no strobe for that pulse.

Source files
------------

// File: rtl/pwm_halfbridge_capture.sv
// Half-bridge gate-drive capture: reconstructs a 12-bit duty code and the PWM period
// from the synchronized high-side/low-side drives, with static-level timeout decode.
//   state | meaning
//   IDLE  | no pulse being timed (after reset or a static decode)
//   HIGH  | selected source is high, width counter running
//   LOW   | selected source is low, waiting for the next rising edge
module pwm_halfbridge_capture #(
    parameter int TIMEOUT  = 8192,
    parameter int MIDSCALE = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PWM_IN_HI,
    input  logic        PWM_IN_LO,
    output logic [31:0] DUTY_OUT,
    output logic        DUTY_VALID,
    output logic [15:0] PERIOD_OUT,
    output logic        NO_SIGNAL,
    output logic        FAULT
);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_H, SRC_L} src_t;

    localparam logic [15:0] LP_TIMEOUT  = 16'(TIMEOUT);
    localparam logic [13:0] LP_MID_SUM  = 14'(MIDSCALE);
    localparam logic [11:0] LP_MID_DUTY = (MIDSCALE > 4095) ? 12'hFFF : 12'(MIDSCALE);

    logic r_hi_s1, r_hi_s2, r_hi_d;
    logic r_lo_s1, r_lo_s2, r_lo_d;

    // Edge registers hold the raw synchronized levels so that all-zero reset means no edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi_s1 <= 1'b0;
            r_hi_s2 <= 1'b0;
            r_hi_d  <= 1'b0;
            r_lo_s1 <= 1'b0;
            r_lo_s2 <= 1'b0;
            r_lo_d  <= 1'b0;
        end else begin
            r_hi_s1 <= PWM_IN_HI;
            r_hi_s2 <= r_hi_s1;
            r_hi_d  <= r_hi_s2;
            r_lo_s1 <= PWM_IN_LO;
            r_lo_s2 <= r_lo_s1;
            r_lo_d  <= r_lo_s2;
        end
    end

    logic w_h, w_h_prev, w_l, w_l_prev;
    logic w_h_rise, w_h_fall, w_l_rise, w_l_fall, w_any_edge;

    assign w_h        = ~r_hi_s2;
    assign w_h_prev   = ~r_hi_d;
    assign w_l        = r_lo_s2;
    assign w_l_prev   = r_lo_d;
    assign w_h_rise   = w_h & ~w_h_prev;
    assign w_h_fall   = ~w_h & w_h_prev;
    assign w_l_rise   = w_l & ~w_l_prev;
    assign w_l_fall   = ~w_l & w_l_prev;
    assign w_any_edge = w_h_rise | w_h_fall | w_l_rise | w_l_fall;

    state_t      r_state;
    src_t        r_src;
    src_t        r_per_src;
    logic [11:0] r_width;
    logic [15:0] r_period_cnt;
    logic [15:0] r_idle_cnt;
    logic [11:0] r_duty;
    logic        r_duty_valid;
    logic [15:0] r_period_out;
    logic        r_no_signal;
    logic        r_fault;
    logic        r_fault_pre;

    logic        w_take_h, w_take_l, w_take, w_same_src;
    logic        w_src_level, w_fall, w_timeout, w_fault_cond;
    logic [15:0] w_idle_next;
    logic [13:0] w_l_sum;
    logic [11:0] w_l_duty;

    // A rising edge on the channel not currently selected always reselects (aborts the pulse).
    assign w_take_h = w_h_rise &
                      (((r_state != ST_HIGH) & ~w_l) |
                       ((r_state != ST_IDLE) & (r_src == SRC_L)));
    assign w_take_l = w_l_rise & ~w_take_h &
                      (((r_state != ST_HIGH) & w_h) |
                       ((r_state != ST_IDLE) & (r_src == SRC_H)));
    assign w_take     = w_take_h | w_take_l;
    assign w_same_src = (w_take_h & (r_per_src == SRC_H)) | (w_take_l & (r_per_src == SRC_L));

    assign w_src_level = ((r_src == SRC_H) & w_h) | ((r_src == SRC_L) & w_l);
    assign w_fall      = (r_state == ST_HIGH) &
                         (((r_src == SRC_H) & w_h_fall) | ((r_src == SRC_L) & w_l_fall));

    // Any edge clears the idle count, so a coincident falling edge always beats the timeout.
    assign w_idle_next = w_any_edge ? 16'd0 :
                         (r_idle_cnt == 16'hFFFF) ? r_idle_cnt : r_idle_cnt + 16'd1;
    assign w_timeout   = ~w_any_edge & (w_idle_next == LP_TIMEOUT);

    assign w_l_sum      = LP_MID_SUM + {2'b00, r_width} - 14'd1;
    assign w_l_duty     = (w_l_sum > 14'd4095) ? 12'hFFF : w_l_sum[11:0];
    assign w_fault_cond = w_l & ~w_h;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_src        <= SRC_NONE;
            r_per_src    <= SRC_NONE;
            r_width      <= 12'd0;
            r_period_cnt <= 16'd0;
            r_idle_cnt   <= 16'd0;
            r_duty       <= 12'd0;
            r_duty_valid <= 1'b0;
            r_period_out <= 16'd0;
            r_no_signal  <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_pre  <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            r_idle_cnt   <= w_timeout ? 16'd0 : w_idle_next;

            r_fault_pre <= w_fault_cond;
            if (w_fault_cond && r_fault_pre)
                r_fault <= 1'b1;

            if (w_h_rise || w_l_rise)
                r_no_signal <= 1'b0;

            if (w_take) begin
                if (w_same_src)
                    r_period_out <= r_period_cnt;
                r_period_cnt <= 16'd1;
                r_per_src    <= w_take_h ? SRC_H : SRC_L;
            end else if (r_period_cnt != 16'hFFFF) begin
                r_period_cnt <= r_period_cnt + 16'd1;
            end

            if (r_state == ST_HIGH && w_src_level && r_width != 12'hFFF)
                r_width <= r_width + 12'd1;

            if (w_fall) begin
                r_state      <= ST_LOW;
                r_duty_valid <= 1'b1;
                r_duty       <= (r_src == SRC_H) ? r_width - 12'd1 : w_l_duty;
            end else if (w_timeout) begin
                case ({w_h, w_l})
                    2'b10: begin
                        r_duty       <= LP_MID_DUTY;
                        r_duty_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_src        <= SRC_NONE;
                    end
                    2'b00: begin
                        r_no_signal  <= 1'b1;
                        r_duty       <= 12'd0;
                        r_duty_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_src        <= SRC_NONE;
                    end
                    2'b11: begin
                        r_duty       <= 12'hFFF;
                        r_duty_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_src        <= SRC_L;
                    end
                    default: ;
                endcase
            end

            if (w_take) begin
                r_state <= ST_HIGH;
                r_src   <= w_take_h ? SRC_H : SRC_L;
                r_width <= 12'd1;
            end
        end
    end

    assign DUTY_OUT   = {20'd0, r_duty};
    assign DUTY_VALID = r_duty_valid;
    assign PERIOD_OUT = r_period_out;
    assign NO_SIGNAL  = r_no_signal;
    assign FAULT      = r_fault;

endmodule
